// File: rtl/banked_regfile_pkg.sv
// Shared types and address-map helpers for the banked register file.
// Build option: BANKED_REGFILE_BYPASS_EN enables write-to-read forwarding.
package banked_regfile_pkg;

    // Special-register addresses for the default 4-bit register address.
    localparam int unsigned REGFILE_ADDR_W = 4;
    localparam int unsigned SP_ADDR        = (1 << REGFILE_ADDR_W) - 3;
    localparam int unsigned SR_ADDR        = (1 << REGFILE_ADDR_W) - 2;
    localparam int unsigned PC_ADDR        = (1 << REGFILE_ADDR_W) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clear_state_e;

    typedef enum logic [1:0] {
        ADDR_BANKED   = 2'd0,
        ADDR_SCRATCH  = 2'd1,
        ADDR_SPECIAL  = 2'd2,
        ADDR_UNMAPPED = 2'd3
    } addr_class_e;

    // Banked first, scratch next, SP/SR/PC in the top three slots.
    function automatic addr_class_e classify_addr(
        input int unsigned addr,
        input int unsigned addr_w,
        input int unsigned bank_regs,
        input int unsigned scratch_regs
    );
        if (addr < bank_regs)                         return ADDR_BANKED;
        else if (addr < bank_regs + scratch_regs)     return ADDR_SCRATCH;
        else if (addr >= (32'd1 << addr_w) - 32'd3)   return ADDR_SPECIAL;
        else                                          return ADDR_UNMAPPED;
    endfunction

endpackage

// File: rtl/banked_regfile_if.sv
// Bus bundle between decode/writeback and the banked register file.
interface banked_regfile_if #(
    parameter int DATA_W     = 16,
    parameter int NUM_BANKS  = 256,
    parameter int READ_PORTS = 3,
    parameter int ADDR_W     = 4
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic [BANK_W-1:0]            bank_sel;
    logic [READ_PORTS*ADDR_W-1:0] read_addr;
    logic [READ_PORTS*DATA_W-1:0] read_data;
    logic [ADDR_W-1:0]            write_addr;
    logic [DATA_W-1:0]            write_data;
    logic                         write_en;
    logic [DATA_W-1:0]            SP;
    logic [DATA_W-1:0]            SR;
    logic [DATA_W-1:0]            PC;
    logic                         clear_req;
    logic [BANK_W-1:0]            clear_bank;
    logic                         clear_busy;
    logic                         clear_done;

    modport master (
        output bank_sel, read_addr, write_addr, write_data, write_en,
               SP, SR, PC, clear_req, clear_bank,
        input  read_data, clear_busy, clear_done
    );

    modport slave (
        input  bank_sel, read_addr, write_addr, write_data, write_en,
               SP, SR, PC, clear_req, clear_bank,
        output read_data, clear_busy, clear_done
    );

endinterface

// File: rtl/regfile_read_mux.sv
// One combinational read port: address decode plus optional forwarding
// of the same-cycle external write (BANKED_REGFILE_BYPASS_EN).
module regfile_read_mux
    import banked_regfile_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int BANK_REGS    = 8,
    parameter int SCRATCH_REGS = 5,
    parameter int ADDR_W       = 4
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_bank_data,
    input  logic [DATA_W-1:0] i_scratch [SCRATCH_REGS],
    input  logic [DATA_W-1:0] i_sp,
    input  logic [DATA_W-1:0] i_sr,
    input  logic [DATA_W-1:0] i_pc,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_data
);
    localparam int SCR_W = (SCRATCH_REGS > 1) ? $clog2(SCRATCH_REGS) : 1;
    localparam logic [ADDR_W-1:0] SP_A = ADDR_W'((2 ** ADDR_W) - 3);
    localparam logic [ADDR_W-1:0] SR_A = ADDR_W'((2 ** ADDR_W) - 2);

    addr_class_e       w_class;
    logic [SCR_W-1:0]  w_scr_off;
    logic [DATA_W-1:0] w_stored;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_stored  = '0;
        w_class   = classify_addr(32'(i_addr), ADDR_W, BANK_REGS, SCRATCH_REGS);
        w_scr_off = SCR_W'(i_addr - ADDR_W'(BANK_REGS));
        unique case (w_class)
            ADDR_BANKED:  w_stored = i_bank_data;
            ADDR_SCRATCH: w_stored = i_scratch[w_scr_off];
            ADDR_SPECIAL: begin
                if (i_addr == SP_A)      w_stored = i_sp;
                else if (i_addr == SR_A) w_stored = i_sr;
                else                     w_stored = i_pc;
            end
            default:      w_stored = '0;
        endcase
    end

`ifdef BANKED_REGFILE_BYPASS_EN
    // Reads and writes share bank_sel, so an address match is a bank match too.
    logic w_fwd;
    assign w_fwd  = i_wr_en && (i_wr_addr == i_addr) &&
                    ((w_class == ADDR_BANKED) || (w_class == ADDR_SCRATCH));
    assign o_data = w_fwd ? i_wr_data : w_stored;
`else
    logic w_unused;
    assign w_unused = ^{i_wr_en, i_wr_addr, i_wr_data};
    assign o_data   = w_stored;
`endif

endmodule

// File: rtl/banked_regfile.sv
// Parametrised banked CPU register file with a sequential bank-clear engine.
// Build option: BANKED_REGFILE_BYPASS_EN enables same-cycle write forwarding.
module banked_regfile
    import banked_regfile_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int NUM_BANKS    = 256,
    parameter int BANK_REGS    = 8,
    parameter int SCRATCH_REGS = 5,
    parameter int READ_PORTS   = 3,
    parameter int ADDR_W       = 4
) (
    input logic             clock,
    input logic             reset,
    banked_regfile_if.slave bus
);
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int IDX_W     = (BANK_REGS > 1) ? $clog2(BANK_REGS) : 1;
    localparam int SCR_W     = (SCRATCH_REGS > 1) ? $clog2(SCRATCH_REGS) : 1;
    localparam int MEM_DEPTH = NUM_BANKS * BANK_REGS;

    if (BANK_REGS + SCRATCH_REGS + 3 > 2 ** ADDR_W) begin : g_bad_cfg
        $error("banked_regfile: BANK_REGS+SCRATCH_REGS+3 exceeds 2**ADDR_W");
    end

    logic [DATA_W-1:0] r_bank_mem [MEM_DEPTH];
    logic [DATA_W-1:0] r_scratch  [SCRATCH_REGS];
    clear_state_e      r_state;
    clear_state_e      w_state_next;
    logic [BANK_W-1:0] r_clr_bank;
    logic [IDX_W-1:0]  r_idx;

    addr_class_e       w_wr_class;
    logic              w_ext_bank_wr;
    logic              w_ext_scr_wr;
    logic              w_clr_wr;
    logic              w_clr_last;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [SCR_W-1:0]  w_scr_off;

    // An external banked write owns the single RAM write port; the engine stalls.
    always_comb begin
        w_wr_class    = classify_addr(32'(bus.write_addr), ADDR_W, BANK_REGS, SCRATCH_REGS);
        w_ext_bank_wr = bus.write_en && (w_wr_class == ADDR_BANKED);
        w_ext_scr_wr  = bus.write_en && (w_wr_class == ADDR_SCRATCH);
        w_wr_idx      = bus.write_addr[IDX_W-1:0];
        w_scr_off     = SCR_W'(bus.write_addr - ADDR_W'(BANK_REGS));
        w_clr_wr      = (r_state == CLEAR) && !w_ext_bank_wr && !reset;
        w_clr_last    = w_clr_wr && (r_idx == IDX_W'(BANK_REGS - 1));
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.clear_req) w_state_next = CLEAR;
            CLEAR:   if (w_clr_last)    w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.clear_busy = (r_state == CLEAR);
        bus.clear_done = (r_state == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_clr_bank <= '0;
            r_idx      <= '0;
        end else if ((r_state == IDLE) && bus.clear_req) begin
            r_clr_bank <= bus.clear_bank;
            r_idx      <= '0;
        end else if (w_clr_wr && !w_clr_last) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // NOTE: bank storage has no reset so it maps onto RAM; the clear engine zeroes banks.
    always_ff @(posedge clock) begin
        if (w_ext_bank_wr)
            r_bank_mem[{bus.bank_sel, w_wr_idx}] <= bus.write_data;
        else if (w_clr_wr)
            r_bank_mem[{r_clr_bank, r_idx}] <= '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SCRATCH_REGS; i++) r_scratch[i] <= '0;
        end else if (w_ext_scr_wr) begin
            r_scratch[w_scr_off] <= bus.write_data;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_bank_data;
        logic [DATA_W-1:0] w_data;

        assign w_addr      = bus.read_addr[p*ADDR_W +: ADDR_W];
        assign w_bank_data = r_bank_mem[{bus.bank_sel, w_addr[IDX_W-1:0]}];

        regfile_read_mux #(
            .DATA_W       (DATA_W),
            .BANK_REGS    (BANK_REGS),
            .SCRATCH_REGS (SCRATCH_REGS),
            .ADDR_W       (ADDR_W)
        ) u_mux (
            .i_addr      (w_addr),
            .i_bank_data (w_bank_data),
            .i_scratch   (r_scratch),
            .i_sp        (bus.SP),
            .i_sr        (bus.SR),
            .i_pc        (bus.PC),
            .i_wr_en     (bus.write_en),
            .i_wr_addr   (bus.write_addr),
            .i_wr_data   (bus.write_data),
            .o_data      (w_data)
        );

        assign bus.read_data[p*DATA_W +: DATA_W] = w_data;
    end

endmodule
